gate_sweep_checker: RTL and testbench
=====================================

# gate_sweep_checker

Synthesizable exhaustive-stimulus and response-checking stage for the combinational gate blocks (nor_gate, and_gate, xor_gate, ...). It sits directly around a gate instance. Upstream, it drives the gate's inputs through every input combination. Downstream, it samples the gate's output after a settle window and compares each sample against a parameterized truth table. It reports pass/fail, an error count and the first failing input vector, with a start/done handshake.

## Interface
Parameters:
- N_IN, 2: number of gate inputs; sweep length is 2^N_IN vectors (legal 1..4).
- SETTLE, 2: cycles each vector is held before y_in is sampled (legal ≥1).
- EXPECT, 4'b0001: expected-output truth table, 2^N_IN bits. Bit i is the expected y for input value i (NOR2 default).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset; sampled on rising edge of clk.
- start  in  1  begin a sweep; sampled only in IDLE.
- y_in  in  1  output of the gate under check.
- vec_out  out  N_IN  gate input vector (bit 0 = a, bit 1 = b, ...).
- busy  out  1  high from the start edge until the done cycle ends.
- done  out  1  one-cycle pulse at sweep completion.
- pass  out  1  sweep result; 1 = no mismatches; held until next start.
- err_count  out  N_IN+1  number of mismatching vectors in last sweep.
- first_fail  out  N_IN  input value of the first mismatch; 0 if none.

## Operation
- Reset (rst_n=0 at an edge) sets state IDLE, vec_out=0, busy=0, done=0, pass=0, err_count=0, first_fail=0, step=0, cnt=0. Reset mid-sweep aborts it with no done pulse.
- FSM states: IDLE, APPLY, CHECK, REPORT.
- IDLE: start=1 at an edge sets vec_out=order(0), step=0, cnt=0, err_count=0, first_fail=0, pass=0 and busy=1, then goes to APPLY.
- APPLY: cnt increments each cycle. When cnt==SETTLE-1, the next state is CHECK. vec_out is stable throughout.
- CHECK: one cycle. At its closing edge, y_in is compared with EXPECT[vec_out].
  - On mismatch, err_count increments. If this is the first mismatch of the sweep, first_fail is set to vec_out.
  - If step==2^N_IN-1, go to REPORT.
  - Otherwise step increments, vec_out=order(step+1), cnt=0, and the FSM returns to APPLY.
- REPORT: done=1 and pass=(err_count==0) for this cycle. Next state is IDLE, with busy=0 at the same edge that drops done.
- start while busy is ignored. start held high in IDLE re-triggers on the edge after REPORT.
- err_count cannot overflow, since at most 2^N_IN errors fit in N_IN+1 bits.
- order(k) is binary k by default; see Configuration.
- EXPECT is always indexed by input value, never by step.

## Timing
- Each vector occupies SETTLE+1 cycles: SETTLE APPLY cycles plus 1 CHECK cycle.
- Let edge 0 be the edge that samples start. y_in for step k is sampled at edge (k+1)·(SETTLE+1).
- done is high between edges 2^N_IN·(SETTLE+1) and 2^N_IN·(SETTLE+1)+1. With defaults, that is edges 12 and 13.
- pass, err_count and first_fail are final and stable from the done cycle until the next accepted start.
- vec_out changes only at CHECK-closing edges and at the start edge, never during APPLY.
- All outputs are registered; there is no combinational path from y_in or start to any output.

## Configuration
- GRAY_ORDER_EN defined: order(k) is the Gray code of k (00,01,11,10 for N_IN=2). Exactly one input toggles per step, which allows glitch observation on the gate.
- GRAY_ORDER_EN undefined: order(k)=k in binary (00,01,10,11).
- The truth-table check, latency and handshake are identical in both cases.

## Structure
- Package gate_sweep_pkg contains:
  - the state enum typedef (IDLE, APPLY, CHECK, REPORT);
  - truth-table constants NOR2_TT=4'b0001, OR2_TT=4'b1110, AND2_TT=4'b1000, NAND2_TT=4'b0111, XOR2_TT=4'b0110, XNOR2_TT=4'b1001.
- One sub-module, bin2gray (parameter W), is instantiated only under GRAY_ORDER_EN. Everything else is flat in gate_sweep_checker.

## Test plan
- Defaults, y_in driven by a correct nor_gate, one start pulse:
  - vec_out steps 00,01,10,11, each held 3 cycles;
  - done pulses at edge 12;
  - pass=1, err_count=0, first_fail=0.
- Defaults, y_in tied to 0 (stuck-at-0): err_count=1, first_fail=00, pass=0.
- EXPECT=NOR2_TT, gate under check is xor_gate: mismatches at 00, 01 and 10, so err_count=3, first_fail=00, pass=0.
- Correct nor_gate, start re-pulsed at edge 5:
  - the re-pulse is ignored;
  - exactly one done at edge 12;
  - busy stays high through edges 0–12.
- Correct nor_gate, rst_n=0 for one edge at edge 6:
  - next edge shows vec_out=0, busy=0, pass=0, err_count=0;
  - no done appears;
  - a following start completes normally with pass=1.
- GRAY_ORDER_EN defined, correct nor_gate: vec_out order 00,01,11,10, done at edge 12, pass=1.

Source files
------------

// File: rtl/gate_sweep_pkg.sv
// Shared types and truth-table constants for the gate sweep checker.
// Truth tables are indexed by input value: bit i is the expected output
// when the gate inputs {.., b, a} equal i.
package gate_sweep_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      APPLY  = 2'd1,
      CHECK  = 2'd2,
      REPORT = 2'd3
   } state_t;

   localparam logic [3:0] NOR2_TT  = 4'b0001;
   localparam logic [3:0] OR2_TT   = 4'b1110;
   localparam logic [3:0] AND2_TT  = 4'b1000;
   localparam logic [3:0] NAND2_TT = 4'b0111;
   localparam logic [3:0] XOR2_TT  = 4'b0110;
   localparam logic [3:0] XNOR2_TT = 4'b1001;

endpackage

// File: rtl/gate_sweep_checker_bin2gray.sv
// Binary to reflected Gray code converter, used for the Gray-ordered sweep.
module bin2gray #(
   parameter int W = 2
) (
   input  logic [W-1:0] bin,
   output logic [W-1:0] gray
);

   assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gate_sweep_checker.sv
// Exhaustive stimulus and response checker for a combinational gate.
// Walks vec_out through all 2^N_IN input values, holds each for SETTLE
// cycles, samples y_in in a following CHECK cycle and compares it with
// EXPECT[vec_out]. Reports pass, error count and first failing vector.
// Optional macro GRAY_ORDER_EN: sweep in Gray-code order instead of binary.
module gate_sweep_checker
   import gate_sweep_pkg::*;
#(
   parameter int                     N_IN   = 2,
   parameter int                     SETTLE = 2,
   parameter logic [(1<<N_IN)-1:0]   EXPECT = NOR2_TT
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            y_in,
   output logic [N_IN-1:0] vec_out,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [N_IN:0]   err_count,
   output logic [N_IN-1:0] first_fail
);

   // Settle counter must reach SETTLE (it increments on the last APPLY cycle).
   localparam int              CW        = $clog2(SETTLE + 1);
   localparam logic [CW-1:0]   CNT_LAST  = CW'(SETTLE - 1);
   localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
   localparam logic [N_IN-1:0] STEP_LAST = '1;
   localparam logic [N_IN-1:0] STEP_ONE  = N_IN'(1);
   localparam logic [N_IN:0]   ERR_ONE   = (N_IN+1)'(1);

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic [N_IN-1:0] step, step_nxt;
   logic [N_IN-1:0] vec_nxt;
   logic            busy_nxt;
   logic            done_nxt;
   logic            pass_nxt;
   logic [N_IN:0]   err_nxt;
   logic [N_IN-1:0] ff_nxt;
   logic            mismatch;

   // Index of the vector about to be applied: 0 on start, step+1 after CHECK.
   logic [N_IN-1:0] order_idx;
   logic [N_IN-1:0] order_val;

   // Select which sweep position is loaded next; kept apart from the main
   // next-state logic so the order mapping is a pure feed-forward path.
   always_comb begin
      order_idx = '0;
      if (state == CHECK) begin
         order_idx = step + STEP_ONE;
      end
   end

`ifdef GRAY_ORDER_EN
   bin2gray #(
      .W (N_IN)
   ) u_order (
      .bin  (order_idx),
      .gray (order_val)
   );
`else
   assign order_val = order_idx;
`endif

   // Next-state and next-output logic for the sweep sequencer.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      step_nxt  = step;
      vec_nxt   = vec_out;
      busy_nxt  = busy;
      done_nxt  = 1'b0;
      pass_nxt  = pass;
      err_nxt   = err_count;
      ff_nxt    = first_fail;
      mismatch  = (y_in != EXPECT[vec_out]);

      case (state)
         IDLE: begin
            if (start) begin
               vec_nxt   = order_val;
               step_nxt  = '0;
               cnt_nxt   = '0;
               err_nxt   = '0;
               ff_nxt    = '0;
               pass_nxt  = 1'b0;
               busy_nxt  = 1'b1;
               state_nxt = APPLY;
            end
         end

         APPLY: begin
            // vec_out is held; only the settle counter moves.
            cnt_nxt = cnt + CNT_ONE;
            if (cnt == CNT_LAST) begin
               state_nxt = CHECK;
            end
         end

         CHECK: begin
            if (mismatch) begin
               err_nxt = err_count + ERR_ONE;
               // err_count still zero means this is the sweep's first mismatch.
               if (err_count == '0) begin
                  ff_nxt = vec_out;
               end
            end
            if (step == STEP_LAST) begin
               done_nxt  = 1'b1;
               pass_nxt  = (err_nxt == '0);
               state_nxt = REPORT;
            end else begin
               step_nxt  = step + STEP_ONE;
               vec_nxt   = order_val;
               cnt_nxt   = '0;
               state_nxt = APPLY;
            end
         end

         REPORT: begin
            // busy falls together with done; results stay held.
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Sweep counters and registered outputs; reset aborts any sweep silently.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt        <= '0;
         step       <= '0;
         vec_out    <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_count  <= '0;
         first_fail <= '0;
      end else begin
         cnt        <= cnt_nxt;
         step       <= step_nxt;
         vec_out    <= vec_nxt;
         busy       <= busy_nxt;
         done       <= done_nxt;
         pass       <= pass_nxt;
         err_count  <= err_nxt;
         first_fail <= ff_nxt;
      end
   end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Directed bench for gate_sweep_checker with default parameters.
// A behavioural gate model drives y_in: correct NOR, stuck-at-0, XOR, stuck-at-1.
module tb_gate_sweep_checker;
   import gate_sweep_pkg::*;

   localparam int N_IN   = 2;
   localparam int SETTLE = 2;
   localparam int HOLD   = SETTLE + 1;
   localparam int EDGE_DONE = 4 * HOLD;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic            y_in;
   logic [N_IN-1:0] vec_out;
   logic            busy;
   logic            done;
   logic            pass;
   logic [N_IN:0]   err_count;
   logic [N_IN-1:0] first_fail;

   int n_cmp = 0;
   int n_bad = 0;
   int mode  = 0;

   always #5 clk = ~clk;

   // Gate under check: 0 = NOR, 1 = stuck-at-0, 2 = XOR, 3 = stuck-at-1.
   always_comb begin
      case (mode)
         0:       y_in = ~(vec_out[0] | vec_out[1]);
         1:       y_in = 1'b0;
         2:       y_in = vec_out[0] ^ vec_out[1];
         default: y_in = 1'b1;
      endcase
   end

   gate_sweep_checker #(
      .N_IN   (N_IN),
      .SETTLE (SETTLE),
      .EXPECT (NOR2_TT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .y_in       (y_in),
      .vec_out    (vec_out),
      .busy       (busy),
      .done       (done),
      .pass       (pass),
      .err_count  (err_count),
      .first_fail (first_fail)
   );

   function automatic logic [N_IN-1:0] ord(input int k);
      logic [N_IN-1:0] b;
      b = N_IN'(k);
`ifdef GRAY_ORDER_EN
      return b ^ (b >> 1);
`else
      return b;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One complete sweep starting at edge 0; optional ignored re-pulse at edge 5.
   task automatic run_sweep(input int m, input int exp_err, input int exp_ff,
                            input bit exp_pass, input bit repulse);
      mode  = m;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("e0_busy", 32'(busy), 32'd1);
      chk("e0_vec", 32'(vec_out), 32'(ord(0)));
      chk("e0_pass", 32'(pass), 32'd0);
      chk("e0_err", 32'(err_count), 32'd0);
      chk("e0_done", 32'(done), 32'd0);
      for (int e = 1; e <= EDGE_DONE + 1; e++) begin
         if (repulse && e == 5) start = 1'b1;
         tick();
         start = 1'b0;
         if (e <= EDGE_DONE) begin
            chk($sformatf("vec_e%0d", e), 32'(vec_out),
                32'(ord((e == EDGE_DONE) ? 3 : e / HOLD)));
         end
         chk($sformatf("done_e%0d", e), 32'(done), 32'(e == EDGE_DONE));
         chk($sformatf("busy_e%0d", e), 32'(busy), 32'(e <= EDGE_DONE));
         if (e == EDGE_DONE) begin
            chk("pass", 32'(pass), 32'(exp_pass));
            chk("err_count", 32'(err_count), 32'(exp_err));
            chk("first_fail", 32'(first_fail), 32'(exp_ff));
         end
      end
      chk("pass_held", 32'(pass), 32'(exp_pass));
      chk("err_held", 32'(err_count), 32'(exp_err));
      chk("ff_held", 32'(first_fail), 32'(exp_ff));
   endtask

   initial begin
      int n_done;

      // Reset state
      rst_n = 1'b0;
      tick();
      tick();
      chk("rst_vec", 32'(vec_out), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_pass", 32'(pass), 32'd0);
      chk("rst_err", 32'(err_count), 32'd0);
      chk("rst_ff", 32'(first_fail), 32'd0);
      rst_n = 1'b1;
      tick();

      // Correct NOR gate
      run_sweep(0, 0, 0, 1'b1, 1'b0);
      // Stuck-at-0: only vector 00 (expects 1) fails
      run_sweep(1, 1, 0, 1'b0, 1'b0);
      // XOR against NOR table: 00, 01, 10 fail
      run_sweep(2, 3, 0, 1'b0, 1'b0);
      // Stuck-at-1: 01, 10, 11 fail, first is 01
      run_sweep(3, 3, 1, 1'b0, 1'b0);
      // Correct NOR, start re-pulsed mid-sweep
      run_sweep(0, 0, 0, 1'b1, 1'b1);

      // Reset at edge 6 aborts the sweep
      mode  = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int e = 1; e <= 5; e++) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("abort_vec", 32'(vec_out), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_pass", 32'(pass), 32'd0);
      chk("abort_err", 32'(err_count), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      n_done = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (done) n_done++;
      end
      chk("abort_no_done", 32'(n_done), 32'd0);
      chk("abort_idle_busy", 32'(busy), 32'd0);
      run_sweep(0, 0, 0, 1'b1, 1'b0);

      // start held high re-triggers on the edge after REPORT
      start = 1'b1;
      tick();
      for (int e = 1; e <= EDGE_DONE + 1; e++) tick();
      chk("hold_busy_e13", 32'(busy), 32'd0);
      tick();
      start = 1'b0;
      chk("hold_busy_e14", 32'(busy), 32'd1);
      chk("hold_vec_e14", 32'(vec_out), 32'(ord(0)));
      n_done = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (done) n_done++;
      end
      chk("hold_one_done", 32'(n_done), 32'd1);
      chk("hold_pass", 32'(pass), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
